// File: rtl/pipe_pkg.sv
// Shared types and default widths for the skid-buffered pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int CTRL_W_DEF = 2;
  localparam int DEST_W_DEF = 5;
  localparam int WORD_W     = 32;

endpackage

// File: rtl/pipe_reg_en.sv
// Entry register: sync reset, clear (flush) and load enable; clear beats load.
// One cycle write latency, holds its value when neither clr nor ld is asserted.
module pipe_reg_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_q <= '0;
    end else if (ld) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with 2-entry skid buffer: 1-cycle latency, full throughput;
// in_ready is registered and drops only when both entries are held.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = 2 * WORD_W,
  parameter int DEST_W = DEST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        count
);

  localparam int ENT_W = CTRL_W + DATA_W + DEST_W;

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic             accept, rel;
  logic             main_ld, main_src_skid, main_drain, skid_ld;
  logic [ENT_W-1:0] main_d, main_q, skid_q, in_ent;

  assign accept = in_valid & in_ready_q;
  assign rel    = out_valid & out_ready;
  assign in_ent = {in_ctrl, in_data, in_dest};

  always_comb begin
    state_d       = state_q;
    main_ld       = 1'b0;
    main_src_skid = 1'b0;
    main_drain    = 1'b0;
    skid_ld       = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_ld = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && rel) begin
          main_ld = 1'b1;
        end else if (accept) begin
          skid_ld = 1'b1;
          state_d = TWO;
        end else if (rel) begin
          // Zero MAIN on drain so an idle stage always presents a clean bubble.
          main_drain = 1'b1;
          state_d    = EMPTY;
        end
      end
      TWO: begin
        if (rel) begin
          main_ld       = 1'b1;
          main_src_skid = 1'b1;
          state_d       = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  assign main_d = main_src_skid ? skid_q : in_ent;

  pipe_reg_en #(.WIDTH(ENT_W)) u_main (
    .clk (clk),
    .rst (rst),
    .clr (flush | main_drain),
    .ld  (main_ld),
    .d_i (main_d),
    .q_o (main_q)
  );

  pipe_reg_en #(.WIDTH(ENT_W)) u_skid (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .ld  (skid_ld),
    .d_i (in_ent),
    .q_o (skid_q)
  );

  assign {out_ctrl, out_data, out_dest} = main_q;
  assign out_valid = (state_q != EMPTY);
  assign count     = {state_q == TWO, state_q == ONE};
  assign in_ready  = in_ready_q;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline-stage register for the processor datapath; successor to the fixed-width, always-load stage latches between pipeline stages.
- Carries a control field, a data payload and a destination-register index.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and a synchronous flush that inserts a bubble.
- Instantiated between any two stages (e.g. MEM→WB, EX→MEM) in place of hand-built per-field latches.

Parameters:
- CTRL_W, 2, width of control bits (e.g. MemToReg, RegWrite); 0 on a bubble.
- DATA_W, 64, width of payload (e.g. MemRes and ALURes concatenated).
- DEST_W, 5, width of destination register index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all held entries at the next edge.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  control field.
- in_data  in  DATA_W  payload.
- in_dest  in  DEST_W  destination index.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control of head entry.
- out_data  out  DATA_W  payload of head entry.
- out_dest  out  DEST_W  destination of head entry.
- count  out  2  entries held (0..2).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. `rst` has priority over everything.
- Reset values: all registers 0, state EMPTY, out_valid=0, out_ctrl/out_data/out_dest=0, count=0, in_ready=1.
- Storage: MAIN register drives out_* directly, with no combinational path from inputs. SKID register holds an overflow entry.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Release = out_valid & out_ready.
- in_ready is a registered function of state: 1 in EMPTY and ONE, 0 in TWO. There is no combinational path from out_ready.
- States and transitions (edge-evaluated, no flush):
  - EMPTY: accept → MAIN<=in, ONE.
  - ONE:
    - accept & release → MAIN<=in, stay ONE.
    - accept & !release → SKID<=in, TWO.
    - !accept & release → EMPTY.
    - neither → hold.
  - TWO:
    - release → MAIN<=SKID, ONE.
    - otherwise hold. No accept is possible because in_ready=0.
- Latency and throughput:
  - Latency is 1 cycle from accept into EMPTY/ONE to out_valid.
  - Sustained throughput is 1 entry/cycle with out_ready=1.
  - Entries leave in strict FIFO order; nothing is dropped or duplicated without flush.
- Flush (synchronous):
  - Next state is EMPTY, count=0, in_ready=1.
  - MAIN and SKID ctrl fields are cleared to 0. Data/dest are cleared to 0 as well, so the bubble is fully deterministic.
  - An entry accepted in the same cycle as flush is discarded.
  - A release in the same cycle still completes downstream; the stage does not re-present it.
- Reset mid-operation has the same effect as flush, plus all registers are zeroed.
- Hold: MAIN/SKID keep their value while not written; out_* stay stable while out_valid & !out_ready.
- Invariants:
  - count == {state==TWO, state==ONE} encoded as 0/1/2.
  - out_valid == (count!=0).
  - out_ctrl==0 whenever out_valid==0.

Decomposition:
- Shared package pipe_pkg:
  - state enum {EMPTY, ONE, TWO};
  - default width constants CTRL_W_DEF=2, DEST_W_DEF=5, WORD_W=32.
- Sub-module pipe_reg_en: a parametrised WIDTH register with sync rst, clr (flush) and ld. It is instantiated once for MAIN and once for SKID, each at width CTRL_W+DATA_W+DEST_W.
- FSM and handshake logic sit in pipe_stage_skid.

Test Plan:
- Reset: assert rst 2 cycles → out_valid=0, out_*=0, count=0, in_ready=1 on the first edge after release.
- Streaming: out_ready=1, push ctrl=2'b11 with data=0x1..0x8 and dest=1..8 every cycle → out_data=0x1..0x8 in order, one cycle after each accept, no gaps, count stays 1.
- Backpressure:
  - Push A=0xAA, B=0xBB with out_ready=0 → count=2, in_ready=0, out_data=0xAA held.
  - Raise out_ready → 0xAA then 0xBB, then count=0.
- Flush in TWO: fill with 0x11, 0x22, assert flush one cycle → next cycle count=0, out_valid=0, out_ctrl=0, in_ready=1; 0x11/0x22 never appear.
- Flush with simultaneous accept: state ONE (0x33), flush & in_valid (0x44) same cycle → count=0; 0x44 never appears. The next push 0x55 appears 1 cycle after accept.
- Reset mid-stream: rst during TWO with in_valid=1 → all outputs 0 and in_ready=1 next cycle; subsequent traffic passes normally.
